dstack: RTL and testbench
=========================

DSTACK -- requirements
Module: dstack

Interface
REQ-001 Parameter WORD_WIDTH, default 32, data word width.
REQ-002 Parameter DEPTH, default 32, on-chip entries below top; power of two, 8..32.
REQ-003 Parameter STACK_BASE, default 0, reset value of the memory spill pointer.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 movement  input  2  00 none, 01 push, 10 pop one, 11 pop two.
REQ-007 next_top  input  WORD_WIDTH  value loaded into top on any accepted cycle.
REQ-008 rotate  input  1  rotate request; only meaningful with movement 00.
REQ-009 rotate_addr  input  5  depth n selected for rotate/copy (0 = top).
REQ-010 top, second, third  output  WORD_WIDTH each  depth 0/1/2 contents, registered.
REQ-011 rotate_value  output  WORD_WIDTH  combinational contents at depth rotate_addr.
REQ-012 stall  output  1  combinational; 1 = this cycle's operation is not accepted.
REQ-013 underflow  output  1  one-cycle pulse on a pop with insufficient entries.
REQ-014 count  output  6  valid on-chip entries below top, 0..DEPTH-1.
REQ-015 mem_req, mem_we  output  1 each  memory request and write-enable.
REQ-016 mem_addr, mem_wdata  output  WORD_WIDTH each  memory address and write data.
REQ-017 mem_ack  input  1  one-cycle completion of the outstanding request.
REQ-018 mem_rdata  input  WORD_WIDTH  fill data, valid when mem_ack=1.

Function
REQ-019 Storage: top register plus array e[0..DEPTH-1]; e[0]=second, e[1]=third; count is on-chip depth; mem_sp is the 32-bit memory pointer.
REQ-020 rotate_value: n=0 -> top, else e[n-1]; depth n > count returns stale array contents with no memory access.
REQ-021 FSM states IDLE, SPILL, FILL; spill_need = count >= DEPTH-1; fill_need = count < 3 and mem_sp != STACK_BASE.
REQ-022 stall = (state != IDLE) or spill_need or fill_need; when stall=1, top/e/count hold and inputs are ignored.
REQ-023 IDLE: spill_need -> SPILL (takes priority); otherwise fill_need -> FILL; otherwise stay IDLE.
REQ-024 SPILL: mem_req=1, mem_we=1, mem_addr=mem_sp, mem_wdata=e[count-1], all held stable until mem_ack.
REQ-025 SPILL on mem_ack: mem_sp += 1, count -= 1, mem_req drops the next cycle, -> IDLE.
REQ-026 FILL: mem_req=1, mem_we=0, mem_addr=mem_sp-1, held until mem_ack.
REQ-027 FILL on mem_ack: e[count] <= mem_rdata, count += 1, mem_sp -= 1, -> IDLE.
REQ-028 Push (01, accepted): e[k+1]<=e[k] for all k, e[0]<=top, top<=next_top, count+=1; copy is a push using rotate_value as next_top.
REQ-029 Pop (10): top<=next_top, e[k]<=e[k+1], count-=1.
REQ-030 Pop2 (11): top<=next_top, e[k]<=e[k+2], count-=2.
REQ-031 Shifted-in vacated entries are 0.
REQ-032 Underflow: pop with count=0, or pop2 with count<2, saturates count at 0, zero-fills the vacated entries, loads top<=next_top, and pulses underflow for one cycle.
REQ-033 Rotate (00, rotate=1, n>=1): top<=next_top, e[0]<=top, e[k]<=e[k-1] for 1<=k<=n-1, deeper entries unchanged; n=0 -> top<=next_top only.
REQ-034 movement 00, rotate 0: top<=next_top, nothing else changes.
REQ-035 mem_ack outside SPILL/FILL is ignored; at most one request is outstanding; latency to mem_ack is unbounded.

Reset
REQ-036 While reset=1: top=0, all e=0, count=0, mem_sp=STACK_BASE, state IDLE, mem_req=0, mem_we=0, underflow=0.
REQ-037 Reset mid SPILL/FILL abandons the request: mem_req falls asynchronously, and a later mem_ack is ignored.

Verification
REQ-038 Push 1,2,3 with no stall -> top=3, second=2, third=1, count=2, stall=0 throughout.
REQ-039 Push to count=31 with DEPTH=32 -> stall=1; mem_req=1, mem_we=1, mem_addr=0, mem_wdata=first value pushed; after ack with 3-cycle latency -> count=30, mem_sp=1, stall=0.
REQ-040 From mem_sp=1, pop to count=2 -> FILL with mem_addr=0; ack with rdata=0xAA -> e[2]=0xAA, count=3, mem_sp=0.
REQ-041 Stack top..=5,6,7,8 (top=5), rotate n=3, next_top=rotate_value=8 -> top=8, second=5, third=6, depth-3 entry=7.
REQ-042 count=1, mem_sp=STACK_BASE, pop2 -> underflow=1 for one cycle, count=0, second=0.
REQ-043 Assert reset during SPILL before ack -> mem_req=0 immediately; a later ack causes no change; count=0.

Source files
------------

// File: rtl/dstack.sv
// Data stack with a register top, an on-chip entry array below it, and
// automatic spill/fill of the deepest entry to/from external memory.
module dstack #(
    parameter int          WORD_WIDTH = 32,
    parameter int          DEPTH      = 32,
    parameter logic [31:0] STACK_BASE = 32'd0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            movement,
    input  logic [WORD_WIDTH-1:0] next_top,
    input  logic                  rotate,
    input  logic [4:0]            rotate_addr,
    output logic [WORD_WIDTH-1:0] top,
    output logic [WORD_WIDTH-1:0] second,
    output logic [WORD_WIDTH-1:0] third,
    output logic [WORD_WIDTH-1:0] rotate_value,
    output logic                  stall,
    output logic                  underflow,
    output logic [5:0]            count,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [WORD_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [WORD_WIDTH-1:0] mem_rdata
);

    localparam int         AW          = $clog2(DEPTH);
    localparam logic [5:0] SPILL_LEVEL = 6'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPILL = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

    state_t                state_r, state_s;
    logic [WORD_WIDTH-1:0] top_r, top_s;
    logic [WORD_WIDTH-1:0] e_r [DEPTH];
    logic [WORD_WIDTH-1:0] e_s [DEPTH];
    logic [5:0]            count_r, count_s;
    logic [31:0]           mem_sp_r, mem_sp_s;
    logic                  mem_req_r, mem_req_s;
    logic                  mem_we_r, mem_we_s;
    logic [WORD_WIDTH-1:0] mem_addr_r, mem_addr_s;
    logic [WORD_WIDTH-1:0] mem_wdata_r, mem_wdata_s;
    logic                  underflow_r, underflow_s;
    logic                  spill_need_s;
    logic                  fill_need_s;
    logic [AW-1:0]         rot_idx_s;

    // Spill/fill demand and the resulting stall, all from current state.
    always_comb begin
        spill_need_s = (count_r >= SPILL_LEVEL);
        fill_need_s  = (count_r < 6'd3) && (mem_sp_r != STACK_BASE);
        stall        = (state_r != ST_IDLE) || spill_need_s || fill_need_s;
    end

    // Random-access read at depth rotate_addr; depths past the array read as zero.
    always_comb begin
        rot_idx_s = AW'(rotate_addr - 5'd1);
        if (rotate_addr == 5'd0) begin
            rotate_value = top_r;
        end else if (int'(rotate_addr) <= DEPTH) begin
            rotate_value = e_r[rot_idx_s];
        end else begin
            rotate_value = {WORD_WIDTH{1'b0}};
        end
    end

    // Next-state logic: memory FSM plus stack movement when not stalled.
    always_comb begin
        state_s     = state_r;
        top_s       = top_r;
        e_s         = e_r;
        count_s     = count_r;
        mem_sp_s    = mem_sp_r;
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        underflow_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (spill_need_s) begin
                    // Deepest valid entry goes out; request stays frozen until ack.
                    state_s     = ST_SPILL;
                    mem_req_s   = 1'b1;
                    mem_we_s    = 1'b1;
                    mem_addr_s  = WORD_WIDTH'(mem_sp_r);
                    mem_wdata_s = e_r[AW'(count_r - 6'd1)];
                end else if (fill_need_s) begin
                    state_s    = ST_FILL;
                    mem_req_s  = 1'b1;
                    mem_we_s   = 1'b0;
                    mem_addr_s = WORD_WIDTH'(mem_sp_r - 32'd1);
                end else begin
                    top_s = next_top;
                    case (movement)
                        2'b01: begin
                            for (int k = 1; k < DEPTH; k++) begin
                                e_s[k] = e_r[k-1];
                            end
                            e_s[0]  = top_r;
                            count_s = count_r + 6'd1;
                        end
                        2'b10: begin
                            if (count_r == 6'd0) begin
                                // Empty stack: nothing valid remains, clear it all.
                                for (int k = 0; k < DEPTH; k++) begin
                                    e_s[k] = {WORD_WIDTH{1'b0}};
                                end
                                underflow_s = 1'b1;
                            end else begin
                                for (int k = 0; k < DEPTH - 1; k++) begin
                                    e_s[k] = e_r[k+1];
                                end
                                e_s[DEPTH-1] = {WORD_WIDTH{1'b0}};
                                count_s      = count_r - 6'd1;
                            end
                        end
                        2'b11: begin
                            if (count_r < 6'd2) begin
                                for (int k = 0; k < DEPTH; k++) begin
                                    e_s[k] = {WORD_WIDTH{1'b0}};
                                end
                                count_s     = 6'd0;
                                underflow_s = 1'b1;
                            end else begin
                                for (int k = 0; k < DEPTH - 2; k++) begin
                                    e_s[k] = e_r[k+2];
                                end
                                e_s[DEPTH-2] = {WORD_WIDTH{1'b0}};
                                e_s[DEPTH-1] = {WORD_WIDTH{1'b0}};
                                count_s      = count_r - 6'd2;
                            end
                        end
                        default: begin
                            // Rotate pushes old top down and shifts only the upper n-1 entries.
                            if (rotate && (rotate_addr != 5'd0)) begin
                                e_s[0] = top_r;
                                for (int k = 1; k < DEPTH; k++) begin
                                    if (k < int'(rotate_addr)) begin
                                        e_s[k] = e_r[k-1];
                                    end else begin
                                        e_s[k] = e_r[k];
                                    end
                                end
                            end else begin
                                e_s = e_r;
                            end
                        end
                    endcase
                end
            end
            ST_SPILL: begin
                if (mem_ack) begin
                    state_s   = ST_IDLE;
                    mem_req_s = 1'b0;
                    mem_we_s  = 1'b0;
                    mem_sp_s  = mem_sp_r + 32'd1;
                    count_s   = count_r - 6'd1;
                end else begin
                    state_s = ST_SPILL;
                end
            end
            ST_FILL: begin
                if (mem_ack) begin
                    state_s             = ST_IDLE;
                    mem_req_s           = 1'b0;
                    mem_we_s            = 1'b0;
                    e_s[AW'(count_r)]   = mem_rdata;
                    mem_sp_s            = mem_sp_r - 32'd1;
                    count_s             = count_r + 6'd1;
                end else begin
                    state_s = ST_FILL;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                mem_req_s = 1'b0;
                mem_we_s  = 1'b0;
            end
        endcase
    end

    // State register; reset also drops any outstanding memory request at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            top_r       <= {WORD_WIDTH{1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                e_r[k] <= {WORD_WIDTH{1'b0}};
            end
            count_r     <= 6'd0;
            mem_sp_r    <= STACK_BASE;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {WORD_WIDTH{1'b0}};
            mem_wdata_r <= {WORD_WIDTH{1'b0}};
            underflow_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            top_r       <= top_s;
            e_r         <= e_s;
            count_r     <= count_s;
            mem_sp_r    <= mem_sp_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            underflow_r <= underflow_s;
        end
    end

    assign top       = top_r;
    assign second    = e_r[0];
    assign third     = e_r[1];
    assign count     = count_r;
    assign underflow = underflow_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_dstack.sv
// Directed bench for dstack: push/pop, spill, fill, rotate, underflow, reset abort.
module tb_dstack;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  movement;
    logic [31:0] next_top;
    logic        rotate;
    logic [4:0]  rotate_addr;
    logic [31:0] top, second, third, rotate_value;
    logic        stall, underflow;
    logic [5:0]  count;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dstack #(.WORD_WIDTH(32), .DEPTH(32), .STACK_BASE(32'd0)) dut (
        .clk(clk), .reset(reset), .movement(movement), .next_top(next_top),
        .rotate(rotate), .rotate_addr(rotate_addr), .top(top), .second(second),
        .third(third), .rotate_value(rotate_value), .stall(stall),
        .underflow(underflow), .count(count), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; movement = 2'b00; next_top = 32'd0; rotate = 1'b0;
        rotate_addr = 5'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        tick(); tick();
        check("rst top", top, 32'd0);
        check("rst second", second, 32'd0);
        check("rst third", third, 32'd0);
        check("rst count", 32'(count), 32'd0);
        check("rst mem_req", 32'(mem_req), 32'd0);
        check("rst mem_we", 32'(mem_we), 32'd0);
        check("rst underflow", 32'(underflow), 32'd0);
        check("rst stall", 32'(stall), 32'd0);
        reset = 1'b0;

        // First value lands in top directly, then 2 and 3 are pushed.
        movement = 2'b00; next_top = 32'd1;
        check("p123 stall a", 32'(stall), 32'd0);
        tick();
        movement = 2'b01; next_top = 32'd2;
        check("p123 stall b", 32'(stall), 32'd0);
        tick();
        next_top = 32'd3;
        check("p123 stall c", 32'(stall), 32'd0);
        tick();
        check("p123 top", top, 32'd3);
        check("p123 second", second, 32'd2);
        check("p123 third", third, 32'd1);
        check("p123 count", 32'(count), 32'd2);
        check("p123 stall d", 32'(stall), 32'd0);

        // Keep pushing 4..32: count reaches 31 and e[30] holds value 1.
        for (int v = 4; v <= 32; v++) begin
            next_top = 32'(v);
            tick();
        end
        movement = 2'b01; next_top = 32'd99;   // must be ignored while stalled
        check("spill count31", 32'(count), 32'd31);
        check("spill stall", 32'(stall), 32'd1);
        check("spill top", top, 32'd32);
        tick();
        check("spill req", 32'(mem_req), 32'd1);
        check("spill we", 32'(mem_we), 32'd1);
        check("spill addr", mem_addr, 32'd0);
        check("spill wdata", mem_wdata, 32'd1);
        tick();
        check("spill hold req", 32'(mem_req), 32'd1);
        check("spill hold wdata", mem_wdata, 32'd1);
        check("spill ignore count", 32'(count), 32'd31);
        check("spill ignore top", top, 32'd32);
        tick();
        mem_ack = 1'b1; movement = 2'b00; next_top = 32'd32;
        tick();
        mem_ack = 1'b0;
        check("spill done count", 32'(count), 32'd30);
        check("spill done req", 32'(mem_req), 32'd0);
        check("spill done stall", 32'(stall), 32'd0);
        check("spill done second", second, 32'd31);

        // Pop down to count 2: top walks 31..4; mem_sp=1 forces a fill from address 0.
        rotate_addr = 5'd3;
        for (int i = 0; i < 28; i++) begin
            movement = 2'b10; next_top = 32'(31 - i);
            tick();
        end
        movement = 2'b00; next_top = 32'd4;
        check("fill count2", 32'(count), 32'd2);
        check("fill stall", 32'(stall), 32'd1);
        check("fill top", top, 32'd4);
        check("fill second", second, 32'd3);
        check("fill third", third, 32'd2);
        tick();
        check("fill req", 32'(mem_req), 32'd1);
        check("fill we", 32'(mem_we), 32'd0);
        check("fill addr", mem_addr, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h0000_00AA;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'd0;
        check("fill done count", 32'(count), 32'd3);
        check("fill done req", 32'(mem_req), 32'd0);
        check("fill done stall", 32'(stall), 32'd0);
        check("fill e2", rotate_value, 32'h0000_00AA);
        // mem_sp is back at base: dropping to count 2 must not stall.
        movement = 2'b10; next_top = 32'd3;
        tick();
        movement = 2'b00;
        check("base pop count", 32'(count), 32'd2);
        check("base pop stall", 32'(stall), 32'd0);
        check("base pop second", second, 32'd2);
        check("base pop third", third, 32'h0000_00AA);

        // Underflow: count 1 then pop2; then pop on empty.
        movement = 2'b10; next_top = 32'd2;
        tick();
        check("uf pre count", 32'(count), 32'd1);
        movement = 2'b11; next_top = 32'h33;
        tick();
        movement = 2'b00;
        check("uf2 pulse", 32'(underflow), 32'd1);
        check("uf2 count", 32'(count), 32'd0);
        check("uf2 second", second, 32'd0);
        check("uf2 top", top, 32'h33);
        tick();
        check("uf2 pulse end", 32'(underflow), 32'd0);
        movement = 2'b10; next_top = 32'h44;
        tick();
        movement = 2'b00;
        check("uf1 pulse", 32'(underflow), 32'd1);
        check("uf1 count", 32'(count), 32'd0);
        check("uf1 top", top, 32'h44);
        tick();
        check("uf1 pulse end", 32'(underflow), 32'd0);

        // Rotate: build top..=5,6,7,8 then rotate depth 3 with next_top=8.
        movement = 2'b00; next_top = 32'd8; tick();
        movement = 2'b01; next_top = 32'd7; tick();
        next_top = 32'd6; tick();
        next_top = 32'd5; tick();
        movement = 2'b00;
        check("rot pre value", rotate_value, 32'd8);
        check("rot pre count", 32'(count), 32'd3);
        rotate = 1'b1; next_top = 32'd8;
        tick();
        rotate = 1'b0;
        check("rot top", top, 32'd8);
        check("rot second", second, 32'd5);
        check("rot third", third, 32'd6);
        check("rot depth3", rotate_value, 32'd7);
        check("rot count", 32'(count), 32'd3);
        rotate_addr = 5'd0;
        #1;
        check("rot n0 read", rotate_value, 32'd8);
        rotate = 1'b1; next_top = 32'h55;
        tick();
        rotate = 1'b0;
        check("rot0 top", top, 32'h55);
        check("rot0 second", second, 32'd5);
        check("rot0 third", third, 32'd6);

        // Refill to a spill, then reset before the ack arrives.
        movement = 2'b01;
        for (int i = 0; i < 28; i++) begin
            next_top = 32'(100 + i);
            tick();
        end
        movement = 2'b00;
        check("rs count31", 32'(count), 32'd31);
        tick();
        check("rs req", 32'(mem_req), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("rs req drop", 32'(mem_req), 32'd0);
        check("rs count", 32'(count), 32'd0);
        check("rs top", top, 32'd0);
        #1;
        reset = 1'b0; next_top = 32'd0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("rs late ack count", 32'(count), 32'd0);
        check("rs late ack req", 32'(mem_req), 32'd0);
        check("rs late ack stall", 32'(stall), 32'd0);
        check("rs late ack second", second, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
